// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared widths and timing constants for the button debouncer
package debounce_pkg;

    localparam int CLK_HZ = 50_000_000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    // Counter width for a value range of n states; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: synchroniser, debounce window, hold timer, pulses
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DB_W   = cnt_w(DB_CYCLES);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES + 1);
    localparam logic              POL      = (ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    logic              sync0_q, sync1_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;

    always_comb begin
        db_cnt_d = '0;
        state_d  = state_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        if (sync1_q != state_q) begin
            if (db_cnt_q == DB_LAST) begin
                state_d = sync1_q;
                press_d = sync1_q;
                rel_d   = !sync1_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Long pulse is withheld if the release lands on the same edge.
        hold_d = '0;
        long_d = 1'b0;
        if (state_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            long_d = state_d && (hold_q == HOLD_PRE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= 1'b0;
            hold_q   <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            sync0_q  <= btn_i ^ POL;
            sync1_q  <= sync0_q;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N_CH independent debounced buttons with a registered any-pressed flag
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] state_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic            any_o
);

    logic any_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_i    (btn_in[i]),
            .state_o  (state_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i]),
            .long_o   (long_o[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |state_o;
        end
    end

    assign any_o = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed bench for debounce_multi (DB=8, HOLD=20, 4 channels)
module tb_debounce_multi;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int HC = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_al = '1;
    logic [N-1:0] state, press, rel, lng;
    logic         any;
    logic [N-1:0] state_al, press_al, rel_al, lng_al;
    logic         any_al;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .state_o(state), .press_o(press), .release_o(rel), .long_o(lng), .any_o(any)
    );

    debounce_multi #(.N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_al),
        .state_o(state_al), .press_o(press_al), .release_o(rel_al), .long_o(lng_al), .any_o(any_al)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset just released.
    task automatic test_reset();
        tick();
        rst_n  = 1'b0;
        btn    = '0;
        btn_al = '1;
        #1;
        total++;
        if ({state, press, rel, lng, any} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {state, press, rel, lng, any});
        end
        total++;
        if ({state_al, press_al, rel_al, lng_al, any_al} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs_al got=%h want=0", {state_al, press_al, rel_al, lng_al, any_al});
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_press_long();
        test_reset();
        btn[0] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            total++;
            if (state[0] !== (e >= 10) || press[0] !== (e == 10) || lng[0] !== (e == 30)
                || rel[0] !== 1'b0 || any !== (e >= 11)) begin
                bad++;
                $display("FAIL press_long e=%0d st=%b pr=%b lg=%b rl=%b any=%b", e, state[0], press[0], lng[0], rel[0], any);
            end
        end
    endtask

    task automatic test_glitch();
        test_reset();
        btn[1] = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 6) btn[1] = 1'b0;
            tick();
            total++;
            if (state[1] !== 1'b0 || press[1] !== 1'b0 || rel[1] !== 1'b0) begin
                bad++;
                $display("FAIL glitch e=%0d st=%b pr=%b rl=%b want 0", e, state[1], press[1], rel[1]);
            end
        end
    endtask

    task automatic test_release_short();
        test_reset();
        btn[2] = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 19) btn[2] = 1'b0;
            total++;
            if (state[2] !== (e >= 10 && e < 29) || rel[2] !== (e == 29) || lng[2] !== 1'b0) begin
                bad++;
                $display("FAIL release_short e=%0d st=%b rl=%b lg=%b", e, state[2], rel[2], lng[2]);
            end
        end
    endtask

    task automatic test_active_low();
        test_reset();
        for (int e = 1; e <= 30; e++) begin
            if (e == 4) btn_al[3] = 1'b0;
            tick();
            total++;
            if (state_al !== {(e >= 13), 3'b000} || press_al !== {(e == 13), 3'b000}
                || any_al !== (e >= 14)) begin
                bad++;
                $display("FAIL active_low e=%0d st=%b pr=%b any=%b", e, state_al, press_al, any_al);
            end
        end
    endtask

    task automatic test_simultaneous();
        test_reset();
        btn = 4'b0011;
        for (int e = 1; e <= 14; e++) begin
            tick();
            total++;
            if (press !== ((e == 10) ? 4'b0011 : 4'b0000)) begin
                bad++;
                $display("FAIL simultaneous e=%0d press=%b", e, press);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        btn[0] = 1'b1;
        for (int e = 1; e <= 6; e++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, press, rel, lng, any} !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid_count got=%h want=0", {state, press, rel, lng, any});
        end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            total++;
            if (state[0] !== (e >= 10) || press[0] !== (e == 10)) begin
                bad++;
                $display("FAIL reset_restart e=%0d st=%b pr=%b", e, state[0], press[0]);
            end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, press, rel, lng, any} !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid_hold got=%h want=0", {state, press, rel, lng, any});
        end
        tick();
        btn[0] = 1'b0;
        rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            total++;
            if (lng[0] !== 1'b0 || press[0] !== 1'b0 || rel[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_pulse e=%0d lg=%b pr=%b rl=%b", e, lng[0], press[0], rel[0]);
            end
        end
    endtask

    initial begin
        test_press_long();
        test_glitch();
        test_release_short();
        test_active_low();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of independent button channels (1..32).
REQ-002 The block SHALL have parameter DB_CYCLES, default 1_000_000, meaning debounce window in clk cycles (20 ms at 50 MHz), legal range >= 2.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning long-press threshold in clk cycles after the debounced press (1 s at 50 MHz), legal range >= 2.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 0, where 1 means a raw 0 on btn_in is "pressed".
REQ-005 The block SHALL have port clk, input, 1 bit, system clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port btn_in, input, N_CH bits, raw asynchronous button levels.
REQ-008 The block SHALL have port state_o, output, N_CH bits, debounced pressed level per channel (1 = pressed).
REQ-009 The block SHALL have port press_o, output, N_CH bits, one-cycle pulse on the debounced 0->1 transition.
REQ-010 The block SHALL have port release_o, output, N_CH bits, one-cycle pulse on the debounced 1->0 transition.
REQ-011 The block SHALL have port long_o, output, N_CH bits, one-cycle pulse when the press has lasted HOLD_CYCLES.
REQ-012 The block SHALL have port any_o, output, 1 bit, OR of all state_o bits, registered.

Function
REQ-013 Each channel SHALL normalise its raw input as btn_in[i] XOR ACTIVE_LOW, then pass it through a 2-FF synchroniser; only the second stage (sync) SHALL be used downstream.
REQ-014 Each channel SHALL keep a debounce counter of width clog2(DB_CYCLES) bits.
REQ-015 While sync != state, the counter SHALL increment each cycle; on the cycle the counter equals DB_CYCLES-1 and sync still differs, state SHALL take sync and the counter SHALL clear.
REQ-016 While sync == state, the counter SHALL clear every cycle; any glitch shorter than the window SHALL restart the count from 0.
REQ-017 Latency: if the raw level is first captured by sync stage 0 at edge k and stays stable, state_o SHALL change at edge k+DB_CYCLES+1, exactly.
REQ-018 press_o[i] / release_o[i] SHALL be high during exactly the one cycle in which state_o[i] first shows the new value.
REQ-019 Each channel SHALL keep a hold counter of width clog2(HOLD_CYCLES+1) bits.
REQ-020 The hold counter SHALL clear while state is 0, increment each cycle while state is 1, and saturate at HOLD_CYCLES.
REQ-021 long_o[i] SHALL pulse once, on the cycle the hold counter reaches HOLD_CYCLES, i.e. HOLD_CYCLES cycles after press_o[i].
REQ-022 long_o[i] SHALL NOT repeat until a release and a new press occur.
REQ-023 A release before HOLD_CYCLES SHALL suppress long_o for that press.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-025 any_o SHALL equal the OR of state_o, delayed by one cycle.
REQ-026 All counters SHALL never wrap: the debounce counter SHALL be bounded by REQ-015 and the hold counter by saturation.

Reset
REQ-027 On rst_n low, all outputs SHALL be 0 asynchronously and all counters SHALL be 0.
REQ-028 On rst_n low, the synchroniser flops SHALL load normalised 0 (raw ACTIVE_LOW level).
REQ-029 A button already pressed at reset release SHALL be debounced normally and SHALL produce press_o after DB_CYCLES+1 cycles.
REQ-030 Reset asserted mid-count or mid-hold SHALL discard the progress; no pulse SHALL be emitted for it.

Structure
REQ-031 Package debounce_pkg SHALL hold the width helper (clog2-based counter widths) and cycles-from-time conversion constants (CLK_HZ = 50_000_000).
REQ-032 Sub-module debounce_ch SHALL implement one channel (sync, debounce counter, hold counter, pulses); debounce_multi SHALL instantiate N_CH copies via generate and add the any_o register.

Verification (DB_CYCLES=8, HOLD_CYCLES=20, N_CH=4)
REQ-033 The bench SHALL cover: btn_in[0] rises, captured edge 10, held -> state_o[0]=1 and press_o[0]=1 at edge 19 only; long_o[0] pulse at edge 39.
REQ-034 The bench SHALL cover: btn_in[1] high for 5 cycles then low -> state_o[1], press_o[1] and release_o[1] stay 0.
REQ-035 The bench SHALL cover: press channel 2, release after 10 cycles of state=1 -> release_o[2] pulse 9 cycles after raw fall capture, no long_o[2].
REQ-036 The bench SHALL cover: ACTIVE_LOW=1, btn_in=4'hF at reset, ch3 driven 0 -> press_o[3] after 9 cycles; any_o=1 one cycle after state_o[3].
REQ-037 The bench SHALL cover: channels 0 and 1 pressed on the same edge -> press_o=4'b0011 in a single cycle.
REQ-038 The bench SHALL cover: rst_n pulsed low at count 5 of the debounce window -> all outputs 0 immediately; new window restarts from 0 after release.
